performance_counter_op: RTL and testbench

- Parametrised successor to the fixed-width NAND read/program/erase performance counters. One instance per operation type.
- Measures the per-operation latency from op start to op end and accumulates the sum, maximum, sample count and failure count over a window whose size is software-configured.
- When the window is complete it raises a ready flag, holds a stable snapshot for the host copy, then clears on copy-complete.
- Sits between the NAND channel controller (start/end/fail pulses) and the performance-monitor register slave (config, snapshot readout).

---
 rtl/performance_counter_op.sv | 276 +++++++++++++++++++++++++++
 tb/tb_performance_counter_op.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/performance_counter_op.sv
`default_nettype none
//==============================================================================
// Module   : performance_counter_op
// Brief    : Per-operation latency monitor for one NAND operation type.
//            Measures start-to-end latency of each operation and accumulates
//            sum, maximum, success count, failure count and dropped-completion
//            count over a software-sized window. When the window completes it
//            presents a stable snapshot (o_ready) until the host signals that
//            the copy is complete, then clears and starts a new window.
// Revision : 1.0 - initial release
//==============================================================================
module performance_counter_op #(
  parameter int LAT_WD  = 16,
  parameter int SUM_WD  = 32,
  parameter int REQ_WD  = 12,
  parameter int CFG_WD  = 32,
  parameter int CFG_LSB = 10
) (
  input  logic              i_bus_clk,
  input  logic              i_bus_rst,
  input  logic [CFG_WD-1:0] i_config,
  input  logic              i_op_start,
  input  logic              i_op_end,
  input  logic              i_op_fail,
  input  logic              i_cp_cmplt,
  output logic [SUM_WD-1:0] o_lat_sum,
  output logic [LAT_WD-1:0] o_lat_max,
  output logic [REQ_WD-1:0] o_req_cnt,
  output logic [REQ_WD-1:0] o_fail_cnt,
  output logic [REQ_WD-1:0] o_drop_cnt,
  output logic              o_sum_sat,
  output logic              o_busy,
  output logic              o_ready
);

  //--------------------------------------------------------------------------
  // State encoding and constants
  //--------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [LAT_WD-1:0] C_LAT_ONES = {LAT_WD{1'b1}};
  localparam logic [SUM_WD-1:0] C_SUM_ONES = {SUM_WD{1'b1}};
  localparam logic [LAT_WD-1:0] C_LAT_ONE  = LAT_WD'(1);
  localparam logic [REQ_WD-1:0] C_REQ_ONE  = REQ_WD'(1);
  localparam int                C_EXT_WD   = SUM_WD + 1 - LAT_WD;

  // Saturating +1 shared by the success, failure and drop counters.
  function automatic logic [REQ_WD-1:0] f_sat_inc(input logic [REQ_WD-1:0] v);
    return (&v) ? v : (v + C_REQ_ONE);
  endfunction

  //--------------------------------------------------------------------------
  // Registers
  //--------------------------------------------------------------------------
  state_t              r_state;
  logic                r_busy;
  logic [LAT_WD-1:0]   r_lat;
  logic [SUM_WD-1:0]   r_lat_sum;
  logic [LAT_WD-1:0]   r_lat_max;
  logic [REQ_WD-1:0]   r_req_cnt;
  logic [REQ_WD-1:0]   r_fail_cnt;
  logic [REQ_WD-1:0]   r_drop_cnt;
  logic                r_sum_sat;
  logic                r_ready;

  //--------------------------------------------------------------------------
  // Combinational signals
  //--------------------------------------------------------------------------
  state_t              w_state_nxt;
  logic [REQ_WD-1:0]   w_window;
  logic                w_end_vld;
  logic                w_lat_at_max;
  logic [LAT_WD-1:0]   w_sample;
  logic                w_clear;
  logic                w_acc_en;
  logic                w_drop_en;
  logic                w_lat_sat_evt;

  logic [SUM_WD-1:0]   w_sum_base;
  logic [LAT_WD-1:0]   w_max_base;
  logic [REQ_WD-1:0]   w_req_base;
  logic [REQ_WD-1:0]   w_fail_base;
  logic [REQ_WD-1:0]   w_drop_base;
  logic                w_sat_base;
  logic [SUM_WD:0]     w_sum_ext;

  logic [SUM_WD-1:0]   w_sum_nxt;
  logic [LAT_WD-1:0]   w_max_nxt;
  logic [REQ_WD-1:0]   w_req_nxt;
  logic [REQ_WD-1:0]   w_fail_nxt;
  logic [REQ_WD-1:0]   w_drop_nxt;
  logic                w_sat_nxt;

  // Only the window field of the config word is used; the remaining bits
  // belong to other counters sharing the same register.
  logic                w_cfg_unused;

  assign w_window     = i_config[CFG_LSB +: REQ_WD];
  assign w_cfg_unused = ^i_config;

  // An end pulse only counts when an operation is actually in flight.
  assign w_end_vld    = i_op_end & r_busy;
  assign w_lat_at_max = (r_lat == C_LAT_ONES);

  // Sample covers the cycle of the end pulse itself, so it is r_lat+1.
  assign w_sample     = w_lat_at_max ? C_LAT_ONES : (r_lat + C_LAT_ONE);

  assign w_clear      = (r_state == ST_CLEAR);
  assign w_acc_en     = w_end_vld & (r_state != ST_DONE);
  assign w_drop_en    = w_end_vld & (r_state == ST_DONE);

  // Latency saturation marks the window, but never disturbs a held snapshot.
  assign w_lat_sat_evt = r_busy & w_lat_at_max & (r_state != ST_DONE);

  //--------------------------------------------------------------------------
  // Latency measurement: busy flag and per-operation cycle counter
  //--------------------------------------------------------------------------
  // Start always (re)loads the counter; the end of the current op is handled
  // by the accumulator in the same cycle, so start+end keeps busy high.
  always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
    if (i_bus_rst) begin
      r_busy <= 1'b0;
      r_lat  <= '0;
    end else if (i_op_start) begin
      r_busy <= 1'b1;
      r_lat  <= '0;
    end else if (w_end_vld) begin
      r_busy <= 1'b0;
      r_lat  <= '0;
    end else if (r_busy && !w_lat_at_max) begin
      r_lat  <= r_lat + C_LAT_ONE;
    end
  end

  //--------------------------------------------------------------------------
  // Window state machine: state register
  //--------------------------------------------------------------------------
  // Holds the window phase; reset drops any partially built window.
  always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
    if (i_bus_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Window state machine: next-state logic
  //--------------------------------------------------------------------------
  // Completion compares against the registered count (one cycle of lag);
  // a zero window never completes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_op_start) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if ((w_window != '0) && (r_req_cnt == w_window)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_cp_cmplt) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Accumulator next values
  //--------------------------------------------------------------------------
  // CLEAR zeroes the base first so a completion landing in that cycle becomes
  // the first sample of the new window (clear then add).
  always_comb begin
    w_sum_base  = w_clear ? '0   : r_lat_sum;
    w_max_base  = w_clear ? '0   : r_lat_max;
    w_req_base  = w_clear ? '0   : r_req_cnt;
    w_fail_base = w_clear ? '0   : r_fail_cnt;
    w_drop_base = w_clear ? '0   : r_drop_cnt;
    w_sat_base  = w_clear ? 1'b0 : r_sum_sat;

    w_sum_ext   = {1'b0, w_sum_base} + {{C_EXT_WD{1'b0}}, w_sample};

    w_sum_nxt   = w_sum_base;
    w_max_nxt   = w_max_base;
    w_req_nxt   = w_req_base;
    w_fail_nxt  = w_fail_base;
    w_drop_nxt  = w_drop_base;
    w_sat_nxt   = w_sat_base | w_lat_sat_evt;

    if (w_acc_en) begin
      if (i_op_fail) begin
        w_fail_nxt = f_sat_inc(w_fail_base);
      end else begin
        if (w_sum_ext[SUM_WD]) begin
          w_sum_nxt = C_SUM_ONES;
          w_sat_nxt = 1'b1;
        end else begin
          w_sum_nxt = w_sum_ext[SUM_WD-1:0];
        end
        if (w_sample > w_max_base) begin
          w_max_nxt = w_sample;
        end
        w_req_nxt = f_sat_inc(w_req_base);
      end
    end

    if (w_drop_en) begin
      w_drop_nxt = f_sat_inc(w_drop_base);
    end
  end

  //--------------------------------------------------------------------------
  // Accumulator registers
  //--------------------------------------------------------------------------
  // Window statistics; only the drop counter may move while DONE is held.
  always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
    if (i_bus_rst) begin
      r_lat_sum  <= '0;
      r_lat_max  <= '0;
      r_req_cnt  <= '0;
      r_fail_cnt <= '0;
      r_drop_cnt <= '0;
      r_sum_sat  <= 1'b0;
    end else begin
      r_lat_sum  <= w_sum_nxt;
      r_lat_max  <= w_max_nxt;
      r_req_cnt  <= w_req_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_sum_sat  <= w_sat_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Snapshot-ready flag
  //--------------------------------------------------------------------------
  // Registered copy of "in DONE": rises one cycle after entering DONE and
  // falls one cycle after leaving it.
  always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
    if (i_bus_rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= (r_state == ST_DONE);
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign o_lat_sum  = r_lat_sum;
  assign o_lat_max  = r_lat_max;
  assign o_req_cnt  = r_req_cnt;
  assign o_fail_cnt = r_fail_cnt;
  assign o_drop_cnt = r_drop_cnt;
  assign o_sum_sat  = r_sum_sat;
  assign o_busy     = r_busy;
  assign o_ready    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_performance_counter_op.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_performance_counter_op
// Brief    : Scoreboard bench for performance_counter_op. Stimulus pushes
//            expected snapshots; a monitor pops them either immediately or on
//            the rising edge of o_ready and compares. A second instance with
//            narrow latency/sum widths exercises saturation.
// Revision : 1.0 - initial release
//==============================================================================
module tb_performance_counter_op;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg0, cfg1;
  logic        op_start, op_end, op_fail, cp_cmplt;

  logic [31:0] sum0;
  logic [15:0] max0;
  logic [11:0] req0, fail0, drop0;
  logic        sat0, busy0, ready0;

  logic [7:0]  sum1;
  logic [3:0]  max1;
  logic [11:0] req1, fail1, drop1;
  logic        sat1, busy1, ready1;

  always #5 clk = ~clk;

  performance_counter_op u_dut (
    .i_bus_clk (clk),      .i_bus_rst (rst),       .i_config  (cfg0),
    .i_op_start(op_start), .i_op_end  (op_end),    .i_op_fail (op_fail),
    .i_cp_cmplt(cp_cmplt), .o_lat_sum (sum0),      .o_lat_max (max0),
    .o_req_cnt (req0),     .o_fail_cnt(fail0),     .o_drop_cnt(drop0),
    .o_sum_sat (sat0),     .o_busy    (busy0),     .o_ready   (ready0)
  );

  performance_counter_op #(.LAT_WD(4), .SUM_WD(8)) u_sat (
    .i_bus_clk (clk),      .i_bus_rst (rst),       .i_config  (cfg1),
    .i_op_start(op_start), .i_op_end  (op_end),    .i_op_fail (op_fail),
    .i_cp_cmplt(cp_cmplt), .o_lat_sum (sum1),      .o_lat_max (max1),
    .o_req_cnt (req1),     .o_fail_cnt(fail1),     .o_drop_cnt(drop1),
    .o_sum_sat (sat1),     .o_busy    (busy1),     .o_ready   (ready1)
  );

  // imm=1: compare at the next falling edge; imm=0: compare when o_ready rises.
  typedef struct {
    string       name;
    bit          imm;
    bit          sel;
    int unsigned sum, max, req, fail, drop;
    bit          sat, busy, ready;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string name, input bit imm, input bit sel,
                      input int unsigned sum, input int unsigned max,
                      input int unsigned req, input int unsigned fail,
                      input int unsigned drop, input bit sat,
                      input bit busy, input bit ready);
    exp_t e;
    e.name = name; e.imm = imm; e.sel = sel;
    e.sum = sum; e.max = max; e.req = req; e.fail = fail; e.drop = drop;
    e.sat = sat; e.busy = busy; e.ready = ready;
    q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    int unsigned a_sum, a_max, a_req, a_fail, a_drop;
    bit          a_sat, a_busy, a_ready;
    if (e.sel) begin
      a_sum = {24'd0, sum1}; a_max = {28'd0, max1};
      a_req = {20'd0, req1}; a_fail = {20'd0, fail1}; a_drop = {20'd0, drop1};
      a_sat = sat1; a_busy = busy1; a_ready = ready1;
    end else begin
      a_sum = sum0; a_max = {16'd0, max0};
      a_req = {20'd0, req0}; a_fail = {20'd0, fail0}; a_drop = {20'd0, drop0};
      a_sat = sat0; a_busy = busy0; a_ready = ready0;
    end
    checks++;
    if (a_sum != e.sum || a_max != e.max || a_req != e.req || a_fail != e.fail ||
        a_drop != e.drop || a_sat != e.sat || a_busy != e.busy || a_ready != e.ready) begin
      errors++;
      $display("FAIL %s: got sum=%0d max=%0d req=%0d fail=%0d drop=%0d sat=%0b busy=%0b ready=%0b; want sum=%0d max=%0d req=%0d fail=%0d drop=%0d sat=%0b busy=%0b ready=%0b",
               e.name, a_sum, a_max, a_req, a_fail, a_drop, a_sat, a_busy, a_ready,
               e.sum, e.max, e.req, e.fail, e.drop, e.sat, e.busy, e.ready);
    end
  endtask

  // Monitor: the only process that makes comparisons.
  initial begin
    bit   prev;
    int   wait_cnt;
    exp_t e;
    prev = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].imm) begin
        e = q.pop_front();
        compare(e);
      end
      if (ready0 && !prev) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          compare(e);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready rise, want no snapshot pending");
        end
        wait_cnt = 0;
      end else if (q.size() > 0) begin
        wait_cnt++;
        if (wait_cnt > 2000) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL %s: got no ready within 2000 cycles, want ready=1", e.name);
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
      prev = ready0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then end pulse exactly lat cycles later.
  task automatic op(input int lat, input bit fail);
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (lat - 1) tick();
    op_end  = 1'b1;
    op_fail = fail;
    tick();
    op_end  = 1'b0;
    op_fail = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (ready0) break;
      tick();
    end
  endtask

  task automatic copy_and_clear(input string name);
    cp_cmplt = 1'b1;
    tick();
    cp_cmplt = 1'b0;
    tick();
    push(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg0 = 32'd3 << 10; cfg1 = 32'd0;
    op_start = 1'b0; op_end = 1'b0; op_fail = 1'b0; cp_cmplt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    push("reset_main", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("reset_sat",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Window 3: latencies 4, 10, 6.
    push("win3_snapshot", 0, 0, 20, 10, 3, 0, 0, 0, 0, 1);
    op(4, 0);  tick();
    op(10, 0); tick();
    op(6, 0);
    wait_ready();
    copy_and_clear("win3_clear");

    // Window 2: one failure then two successes of latency 3.
    cfg0 = 32'd2 << 10;
    push("win2_snapshot", 0, 0, 6, 3, 2, 1, 0, 0, 0, 1);
    op(5, 1); tick();
    op(3, 0); tick();
    op(3, 0);
    wait_ready();
    // Completions while DONE only count as drops.
    op(2, 0); tick();
    op(2, 0); tick();
    push("done_drops", 1, 0, 6, 3, 2, 1, 2, 0, 0, 1);
    tick();
    copy_and_clear("drop_clear");

    // Same-cycle end+start: first op latency 7, next op measured from 0.
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (6) tick();
    op_end = 1'b1; op_start = 1'b1;
    tick();
    op_end = 1'b0; op_start = 1'b0;
    push("same_cycle", 1, 0, 7, 7, 1, 0, 0, 0, 1, 0);
    tick();
    push("same_cycle_snapshot", 0, 0, 10, 7, 2, 0, 0, 0, 0, 1);
    tick();
    op_end = 1'b1;
    tick();
    op_end = 1'b0;
    wait_ready();
    copy_and_clear("same_cycle_clear");

    // End while idle is ignored.
    op_end = 1'b1;
    tick();
    op_end = 1'b0;
    push("end_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Asynchronous reset mid-window with an op in flight.
    cfg0 = 32'd3 << 10;
    op(2, 0); tick();
    op(2, 0); tick();
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    tick();
    push("pre_reset", 1, 0, 4, 2, 2, 0, 0, 0, 1, 0);
    tick();
    #1;
    rst = 1'b1;
    push("async_reset_main", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("async_reset_sat",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    cfg0 = 32'd1 << 10;
    push("post_reset_snapshot", 0, 0, 4, 4, 1, 0, 0, 0, 0, 1);
    op(4, 0);
    wait_ready();
    copy_and_clear("post_reset_clear");

    // Saturation: 20-cycle op on the 4-bit latency instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg0 = 32'd0;
    op(20, 0); tick();
    push("long_op_main", 1, 0, 20, 20, 1, 0, 0, 0, 0, 0);
    push("long_op_sat",  1, 1, 15, 15, 1, 0, 0, 1, 0, 0);
    tick();

    // Sum saturation: 17 x 15 = 255 fits exactly, 18th overflows 8 bits.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (17) begin op(15, 0); tick(); end
    push("sum17_main", 1, 0, 255, 15, 17, 0, 0, 0, 0, 0);
    push("sum17_sat",  1, 1, 255, 15, 17, 0, 0, 0, 0, 0);
    tick();
    repeat (3) begin op(15, 0); tick(); end
    push("sum20_main", 1, 0, 300, 15, 20, 0, 0, 0, 0, 0);
    push("sum20_sat",  1, 1, 255, 15, 20, 0, 0, 1, 0, 0);
    tick();

    for (int i = 0; i < 3000 && q.size() > 0; i++) tick();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
